reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register 0 is hard-wired zero.
REQ-002 Parameter CNTW, default 2: width of each per-register pending-write counter; maximum count CMAX = 2^CNTW-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 issue_valid  input  1  the ID-stage instruction requests issue this cycle.
REQ-006 issue_rs  input  5  source register RS of the ID instruction.
REQ-007 issue_rs_used  input  1  the instruction reads RS.
REQ-008 issue_rt  input  5  source register RT of the ID instruction.
REQ-009 issue_rt_used  input  1  the instruction reads RT.
REQ-010 issue_we  input  1  the instruction writes a register.
REQ-011 issue_dest  input  5  destination register of the ID instruction.
REQ-012 wb_valid  input  1  a non-bubble instruction is in WB this cycle.
REQ-013 wb_we  input  1  the WB instruction writes the register file (RegWrite).
REQ-014 wb_dest  input  5  WB destination register (writeReg).
REQ-015 stall  output  1  combinational; the ID instruction must be held and a bubble sent to EX.
REQ-016 issue_accept  output  1  combinational; issue_valid AND NOT stall.
REQ-017 busy_vec  output  NREG  registered; bit r = (count[r] != 0).
REQ-018 inflight  output  7  registered; sum of all pending-write counts.
REQ-019 underflow  output  1  registered sticky error flag.

Function
REQ-020 The block SHALL hold one CNTW-bit counter count[r] per register r, 1..NREG-1; count[0] SHALL be constant 0.
REQ-021 stall SHALL be 1 when issue_valid=1 and any of: issue_rs_used and count[issue_rs]!=0; issue_rt_used and count[issue_rt]!=0; issue_we and issue_dest!=0 and count[issue_dest]==CMAX.
REQ-022 stall SHALL be 0 whenever issue_valid=0.
REQ-023 Source register 0 SHALL never cause stall.
REQ-024 stall SHALL use registered counts only; a retire to the same register in the same cycle SHALL NOT suppress stall (release visible one cycle after the retire edge).
REQ-025 Issue increment: when issue_accept=1, issue_we=1, issue_dest!=0, count[issue_dest] SHALL increase by 1 at the next edge.
REQ-026 Retire decrement: when wb_valid=1, wb_we=1, wb_dest!=0, count[wb_dest] SHALL decrease by 1 at the next edge.
REQ-027 Simultaneous increment and decrement of the same register SHALL leave its count unchanged.
REQ-028 Simultaneous increment and decrement of different registers SHALL both apply.
REQ-029 Retire to a register whose count is 0 SHALL leave the count at 0 and set underflow=1 at the next edge.
REQ-030 underflow SHALL remain 1 until reset.
REQ-031 A counter SHALL never exceed CMAX; REQ-021 guarantees no increment at CMAX.
REQ-032 inflight SHALL track the net change: +1 per increment, -1 per valid (non-underflow) decrement, unchanged when both occur.
REQ-033 Issue with issue_we=1 and issue_dest=0 SHALL change no state.
REQ-034 Latency: an accepted writer's destination SHALL appear in busy_vec exactly one cycle after the accepting edge.

Reset
REQ-035 On rst=1 at a rising edge, all counts, busy_vec, inflight and underflow SHALL become 0.
REQ-036 rst SHALL take priority over simultaneous issue and retire in the same cycle.
REQ-037 During a cycle with rst=1, stall and issue_accept SHALL still be computed from the current registered counts.

Verification
REQ-038 Issue add r3 (issue_we=1, dest=3) -> next cycle busy_vec[3]=1, inflight=1; next ID uses rs=3 -> stall=1, issue_accept=0.
REQ-039 While count[3]=1, retire wb_dest=3 -> stall stays 1 in the retire cycle, becomes 0 the cycle after; busy_vec[3]=0, inflight=0.
REQ-040 Same cycle: accepted issue dest=5 and retire wb_dest=5 with count[5]=1 -> count[5] stays 1, inflight unchanged.
REQ-041 Three accepted writes to r7 without retire -> count[7]=3; fourth writer to r7 -> stall=1; one retire to r7 -> next cycle stall=0 and fourth accepted.
REQ-042 Retire wb_dest=9 with count[9]=0 -> underflow=1, count[9]=0, inflight unchanged; remains 1 until rst.
REQ-043 rs=0, rt=0 reads with all counts nonzero -> stall=0; rst with count[3]=2 and simultaneous issue dest=3 -> next cycle busy_vec=0, inflight=0.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that gate issue on
// RAW hazards and counter saturation, and release registers as writers retire.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs,
    input  logic            issue_rs_used,
    input  logic [4:0]      issue_rt,
    input  logic            issue_rt_used,
    input  logic            issue_we,
    input  logic [4:0]      issue_dest,
    input  logic            wb_valid,
    input  logic            wb_we,
    input  logic [4:0]      wb_dest,
    output logic            stall,
    output logic            issue_accept,
    output logic [NREG-1:0] busy_vec,
    output logic [6:0]      inflight,
    output logic            underflow
);

    localparam logic [CNTW-1:0] CZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CMAX  = {CNTW{1'b1}};

    logic [CNTW-1:0] count_r [NREG];
    logic [CNTW-1:0] count_nxt_s [NREG];
    logic [NREG-1:0] busy_vec_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [6:0]      inflight_r;
    logic [6:0]      inflight_nxt_s;
    logic            underflow_r;

    logic            rs_hit_s;
    logic            rt_hit_s;
    logic            dest_full_s;
    logic            stall_s;
    logic            inc_s;
    logic            dec_s;
    logic [NREG-1:0] inc_oh_s;
    logic [NREG-1:0] dec_oh_s;
    logic            inc_eff_s;
    logic            dec_eff_s;
    logic            uf_hit_s;

    // Hazard detection from registered counts only; register 0 has no counter.
    always_comb begin
        rs_hit_s    = 1'b0;
        rt_hit_s    = 1'b0;
        dest_full_s = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            rs_hit_s    = rs_hit_s    | ((issue_rs   == 5'(r)) && (count_r[r] != CZERO));
            rt_hit_s    = rt_hit_s    | ((issue_rt   == 5'(r)) && (count_r[r] != CZERO));
            dest_full_s = dest_full_s | ((issue_dest == 5'(r)) && (count_r[r] == CMAX));
        end
        stall_s = issue_valid & ((issue_rs_used & rs_hit_s) |
                                 (issue_rt_used & rt_hit_s) |
                                 (issue_we & dest_full_s));
    end

    assign stall        = stall_s;
    assign issue_accept = issue_valid & ~stall_s;
    assign inc_s        = issue_valid & ~stall_s & issue_we & (issue_dest != 5'd0);
    assign dec_s        = wb_valid & wb_we & (wb_dest != 5'd0);

    // Next counter values; an issue and a retire to the same register cancel.
    always_comb begin
        count_nxt_s[0] = CZERO;
        busy_nxt_s     = {NREG{1'b0}};
        inc_oh_s       = {NREG{1'b0}};
        dec_oh_s       = {NREG{1'b0}};
        inc_eff_s      = 1'b0;
        dec_eff_s      = 1'b0;
        uf_hit_s       = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            inc_oh_s[r] = inc_s & (issue_dest == 5'(r));
            dec_oh_s[r] = dec_s & (wb_dest == 5'(r));
            if (inc_oh_s[r] && !dec_oh_s[r]) begin
                count_nxt_s[r] = count_r[r] + CONE;
                inc_eff_s      = 1'b1;
            end else if (dec_oh_s[r] && !inc_oh_s[r]) begin
                if (count_r[r] != CZERO) begin
                    count_nxt_s[r] = count_r[r] - CONE;
                    dec_eff_s      = 1'b1;
                end else begin
                    count_nxt_s[r] = count_r[r];
                    uf_hit_s       = 1'b1;
                end
            end else begin
                count_nxt_s[r] = count_r[r];
            end
            busy_nxt_s[r] = (count_nxt_s[r] != CZERO);
        end
        inflight_nxt_s = inflight_r + {6'd0, inc_eff_s} - {6'd0, dec_eff_s};
    end

    // State registers; reset wins over any same-cycle issue or retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                count_r[r] <= CZERO;
            end
            busy_vec_r  <= {NREG{1'b0}};
            inflight_r  <= 7'd0;
            underflow_r <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                count_r[r] <= count_nxt_s[r];
            end
            busy_vec_r  <= busy_nxt_s;
            inflight_r  <= inflight_nxt_s;
            underflow_r <= underflow_r | uf_hit_s;
        end
    end

    assign busy_vec  = busy_vec_r;
    assign inflight  = inflight_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios followed by random
// traffic, all checked against a per-register pending-count model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic        issue_rs_used;
    logic [4:0]  issue_rt;
    logic        issue_rt_used;
    logic        issue_we;
    logic [4:0]  issue_dest;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic        stall;
    logic        issue_accept;
    logic [31:0] busy_vec;
    logic [6:0]  inflight;
    logic        underflow;

    int vectors     = 0;
    int miscompares = 0;

    int model_cnt [32];
    int model_infl;
    bit model_uf;
    bit obs_stall;
    bit obs_accept;

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
        .issue_rt(issue_rt), .issue_rt_used(issue_rt_used), .issue_we(issue_we),
        .issue_dest(issue_dest), .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest),
        .stall(stall), .issue_accept(issue_accept), .busy_vec(busy_vec),
        .inflight(inflight), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_stall(input bit iv, input logic [4:0] rs, input bit rsu,
                                       input logic [4:0] rt, input bit rtu,
                                       input bit we, input logic [4:0] d);
        bit s;
        s = 1'b0;
        if (rsu && rs != 5'd0 && model_cnt[rs] > 0) s = 1'b1;
        if (rtu && rt != 5'd0 && model_cnt[rt] > 0) s = 1'b1;
        if (we && d != 5'd0 && model_cnt[d] == 3) s = 1'b1;
        return iv && s;
    endfunction

    task automatic apply(input bit r, input bit iv, input logic [4:0] rs, input bit rsu,
                         input logic [4:0] rt, input bit rtu, input bit we, input logic [4:0] d,
                         input bit wv, input bit ww, input logic [4:0] wd);
        bit exp_stall, inc, dec;
        logic [31:0] exp_busy;
        @(negedge clk);
        rst = r; issue_valid = iv; issue_rs = rs; issue_rs_used = rsu;
        issue_rt = rt; issue_rt_used = rtu; issue_we = we; issue_dest = d;
        wb_valid = wv; wb_we = ww; wb_dest = wd;
        #1;
        exp_stall  = model_stall(iv, rs, rsu, rt, rtu, we, d);
        obs_stall  = stall;
        obs_accept = issue_accept;
        check_val("stall", {31'd0, stall}, {31'd0, exp_stall});
        check_val("accept", {31'd0, issue_accept}, {31'd0, iv && !exp_stall});
        @(posedge clk);
        if (r) begin
            foreach (model_cnt[i]) model_cnt[i] = 0;
            model_infl = 0;
            model_uf   = 1'b0;
        end else begin
            inc = iv && !exp_stall && we && d != 5'd0;
            dec = wv && ww && wd != 5'd0;
            if (!(inc && dec && d == wd)) begin
                if (inc) begin
                    model_cnt[d]++;
                    model_infl++;
                end
                if (dec) begin
                    if (model_cnt[wd] == 0) model_uf = 1'b1;
                    else begin
                        model_cnt[wd]--;
                        model_infl--;
                    end
                end
            end
        end
        #1;
        exp_busy = 32'd0;
        for (int i = 1; i < 32; i++) exp_busy[i] = (model_cnt[i] != 0);
        check_val("busy_vec", busy_vec, exp_busy);
        check_val("inflight", {25'd0, inflight}, model_infl);
        check_val("underflow", {31'd0, underflow}, {31'd0, model_uf});
    endtask

    task automatic issue_w(input logic [4:0] d);
        apply(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, d, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic retire(input logic [4:0] d);
        apply(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, d);
    endtask

    initial begin
        bit iv, rsu, rtu, we, wv, ww, rr, es;
        logic [4:0] rs, rt, d, wd;

        foreach (model_cnt[i]) model_cnt[i] = 0;
        model_infl = 0;
        model_uf   = 1'b0;

        apply(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        check_val("reset_busy", busy_vec, 32'd0);

        // add r3, then a reader of r3 stalls
        issue_w(5'd3);
        check_val("r3_busy", {31'd0, busy_vec[3]}, 32'd1);
        apply(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        check_val("r3_read_stall", {31'd0, obs_stall}, 32'd1);
        // retire r3 in the stall cycle: still stalled, released next cycle
        apply(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd3);
        check_val("r3_retire_cycle_stall", {31'd0, obs_stall}, 32'd1);
        apply(1'b0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
        check_val("r3_released", {31'd0, obs_accept}, 32'd1);

        // simultaneous issue and retire of r5
        issue_w(5'd5);
        apply(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5);
        check_val("r5_same_infl", {25'd0, inflight}, 32'd1);
        retire(5'd5);

        // r7 saturates at three writers
        issue_w(5'd7); issue_w(5'd7); issue_w(5'd7);
        apply(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7);
        check_val("r7_full_stall", {31'd0, obs_stall}, 32'd1);
        issue_w(5'd7);
        check_val("r7_fourth_accept", {31'd0, obs_accept}, 32'd1);
        check_val("r7_infl", {25'd0, inflight}, 32'd3);
        retire(5'd7); retire(5'd7); retire(5'd7);

        // underflow on r9, then sticky
        retire(5'd9);
        check_val("r9_uf", {31'd0, underflow}, 32'd1);
        issue_w(5'd4);
        retire(5'd4);
        check_val("uf_sticky", {31'd0, underflow}, 32'd1);

        // r0 never stalls, and dest 0 changes nothing
        for (int r = 1; r < 32; r++) issue_w(5'(r));
        apply(1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
        check_val("r0_no_stall", {31'd0, obs_stall}, 32'd0);
        check_val("all_busy_infl", {25'd0, inflight}, 32'd31);
        issue_w(5'd3);
        apply(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd6);
        check_val("rst_prio_busy", busy_vec, 32'd0);
        check_val("rst_prio_infl", {25'd0, inflight}, 32'd0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rr  = ($urandom_range(0, 60) == 0);
            iv  = $urandom_range(0, 3) != 0;
            rs  = 5'($urandom_range(0, 11));
            rt  = 5'($urandom_range(0, 11));
            rsu = $urandom_range(0, 1);
            rtu = $urandom_range(0, 1);
            we  = $urandom_range(0, 2) != 0;
            d   = 5'($urandom_range(0, 11));
            wv  = $urandom_range(0, 1);
            ww  = $urandom_range(0, 5) != 0;
            wd  = 5'($urandom_range(0, 11));
            if (model_cnt[wd] == 0 && $urandom_range(0, 7) != 0) ww = 1'b0;
            es = model_stall(iv, rs, rsu, rt, rtu, we, d);
            if (iv && !es && we && d == wd && model_cnt[wd] == 0) ww = 1'b0;
            apply(rr, iv, rs, rsu, rt, rtu, we, d, wv, ww, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
